if_prefetch: RTL

- Instruction-fetch stage directly upstream of the datapath decode in riscv_top.
- Drives the word address of the synchronous instruction ROM (8-bit rom_addr), captures returned 32-bit instructions with their PC into a small prefetch FIFO, and hands them to decode via valid/ready.
- Accepts redirects (branch/jump/trap) from the datapath, flushes buffered and in-flight fetches.

---
 rtl/riscv_pkg.sv | 14 +
 rtl/if_fifo.sv | 62 ++++++
 rtl/if_prefetch.sv | 122 ++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV64 constants and the fetch-entry record passed from fetch to decode.
package riscv_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic            misalign;
  } fetch_entry_t;

endpackage

// File: rtl/if_fifo.sv
// Prefetch buffer: DEPTH-entry synchronous FIFO with flush; head is read from registered storage.
module if_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  fetch_entry_t  din,
  input  logic          pop,
  output fetch_entry_t  dout,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem [DEPTH];
  fetch_entry_t  hold;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          empty;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign do_push = push && !flush;
  assign do_pop  = pop && !empty && !flush;

  // When empty, keep presenting whatever was last on the output.
  assign dout = empty ? hold : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      hold   <= '0;
    end else begin
      hold <= dout;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + PW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(do_push) - CW'(do_pop);
      end
    end
  end

  always @(posedge clk) begin
    if (!rst) assert (!(do_push && count == CW'(DEPTH)));
  end

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch stage: drives the ROM, buffers responses with their PC, hands them to decode.
// Define IF_MISALIGN_TRAP_EN to turn misaligned redirect targets into a single flagged NOP entry.
module if_prefetch #(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter int              DEPTH    = 4,
  parameter int              AW       = 8,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            rom_en,
  output logic [AW-1:0]   rom_addr,
  input  logic [31:0]     rom_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
`ifdef IF_MISALIGN_TRAP_EN
  output logic            out_misalign,
`endif
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = CW + 1;
  localparam int EW = riscv_pkg::XLEN;

  logic [XLEN-1:0]        fetch_pc;
  logic [XLEN-1:0]        inflight_pc;
  logic [XLEN-1:0]        target_pc;
  logic                   inflight;
  logic                   inflight_epoch;
  logic                   inflight_trap;
  logic                   epoch;
  logic                   halted;
  logic                   misaligned;
  logic                   issue;
  logic                   push;
  logic                   pop;
  logic [CW-1:0]          count;
  logic [OW-1:0]          occupancy;
  riscv_pkg::fetch_entry_t push_entry;
  riscv_pkg::fetch_entry_t head;

`ifdef IF_MISALIGN_TRAP_EN
  assign misaligned   = (redirect_pc[1:0] != 2'b00);
  assign target_pc    = redirect_pc;
  assign out_misalign = head.misalign;
`else
  logic unused_bits;
  assign misaligned  = 1'b0;
  assign target_pc   = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_bits = ^{redirect_pc[1:0], head.misalign};
`endif

  // Decode handshake: an entry transfers on any cycle where out_valid && out_ready;
  // out_valid never depends on out_ready, and a transfer coinciding with a redirect still counts.
  assign pop       = out_valid && out_ready;
  assign out_valid = (count != '0);
  assign out_instr = head.instr;
  assign out_pc    = XLEN'(head.pc);

  // Reserve a slot for every outstanding read so the FIFO cannot overflow.
  assign occupancy = OW'(count) + OW'(inflight) - OW'(pop);
  assign issue     = !rst && !redirect_valid && !halted && (occupancy < OW'(DEPTH));
  assign rom_en    = issue;
  assign rom_addr  = fetch_pc[AW+1:2];

  // Responses tagged with an older epoch belong to a fetch stream that was redirected away.
  assign push = inflight && (inflight_epoch == epoch) && !redirect_valid;

  always_comb begin
    push_entry          = '0;
    push_entry.pc       = EW'(inflight_pc);
    push_entry.instr    = inflight_trap ? riscv_pkg::NOP : rom_data;
    push_entry.misalign = inflight_trap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc       <= RESET_PC;
      inflight       <= 1'b0;
      inflight_pc    <= '0;
      inflight_epoch <= 1'b0;
      inflight_trap  <= 1'b0;
      epoch          <= 1'b0;
      halted         <= 1'b0;
    end else if (redirect_valid) begin
      // A misaligned target is queued as a pseudo-response instead of a ROM read.
      epoch          <= ~epoch;
      fetch_pc       <= target_pc;
      halted         <= misaligned;
      inflight       <= misaligned;
      inflight_trap  <= misaligned;
      inflight_pc    <= target_pc;
      inflight_epoch <= ~epoch;
    end else begin
      inflight      <= issue;
      inflight_trap <= 1'b0;
      if (issue) begin
        fetch_pc       <= fetch_pc + XLEN'(4);
        inflight_pc    <= fetch_pc;
        inflight_epoch <= epoch;
      end
    end
  end

  if_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .dout  (head),
    .count (count)
  );

endmodule
